axi_lite_regfile_slave: RTL and testbench
=========================================

Name: axi_lite_regfile_slave

Overview:
- AXI-Lite slave that terminates the five channels driven by the team's AXI-Lite master: 4-bit address, 8-bit data, 4-bit write response.
- Holds a NUM_REGS x 8-bit register file, plus one read-only ID register.
- Captures write address and write data independently and commits a write only when both are held.
- Serves single-beat reads and returns write responses with back-pressure.

Parameters:
NUM_REGS, 15, number of implemented read/write registers at addresses 0..NUM_REGS-1 (max 15)
ID_ADDR, 15, address of the read-only ID register
ID_VALUE, 8'hA5, value returned when ID_ADDR is read

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
read_address  input  4  AR channel address
AR_VALID  input  1  master read address valid
AR_READY  output  1  slave can accept read address
data_read  output  8  R channel data
R_VALID  output  1  read data valid
R_READY  input  1  master accepts read data
write_address  input  4  AW channel address
AW_VALID  input  1  master write address valid
AW_READY  output  1  slave can accept write address
data_write  input  8  W channel data
W_VALID  input  1  master write data valid
W_READY  output  1  slave can accept write data
B_VALID  output  1  write response valid
BRESPONSE  output  4  response code: 0 OKAY, 2 SLVERR, 3 DECERR
B_READY  input  1  master accepts write response

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - aw_full=0, w_full=0, R_VALID=0, B_VALID=0, data_read=0, BRESPONSE=0.
  - All registers are cleared to 0.
  - AR_READY=1, AW_READY=1 and W_READY=1 once reset deasserts.
- Reset asserted mid-transaction drops any held AW/W, pending R or pending B. No commit occurs on that edge.
- READY outputs are decoded only from internal registers; there is no combinational path from any input to any output.
  - AW_READY = !aw_full
  - W_READY = !w_full
  - AR_READY = !R_VALID
- AW handshake (AW_VALID && AW_READY at an edge) latches write_address into aw_addr and sets aw_full.
- W handshake latches data_write into w_data and sets w_full.
- AW and W handshakes are independent; either may come first, or both may land on the same edge.
- Commit occurs at an edge where aw_full && w_full && !B_VALID:
  - aw_addr < NUM_REGS and != ID_ADDR: reg[aw_addr] <= w_data, BRESPONSE <= 0.
  - aw_addr == ID_ADDR: no write, BRESPONSE <= 2.
  - Any other address: no write, BRESPONSE <= 3.
  - In all cases: B_VALID <= 1, aw_full <= 0, w_full <= 0.
- Write latency: AW and W handshake on edge t gives B_VALID=1 after edge t+1.
- A new AW/W may be captured on the commit edge only if its holding register was already empty, which means not the same edge. Peak write rate is one per 2 cycles.
- B_VALID and BRESPONSE hold stable until an edge with B_READY=1. At that edge B_VALID <= 0 and BRESPONSE <= 0.
- While B_VALID=1 the held AW/W stay held and READY stays low, so at most one outstanding write.
- AR handshake at edge t gives R_VALID=1 after edge t:
  - addr < NUM_REGS and != ID_ADDR: data_read = reg[addr].
  - addr == ID_ADDR: data_read = ID_VALUE.
  - Any other address: data_read = 0.
- R_VALID and data_read hold until an edge with R_READY=1. At that edge R_VALID <= 0 and data_read <= 0.
- The AR/R path is fully independent of the write path.
- Read and commit to the same address on the same edge: the read returns the pre-commit value. A read handshaking one or more edges after the commit returns the new value.
- AW_VALID/W_VALID asserted while READY is low are ignored; the master holds them, the slave does not queue them.
- Addresses are 4-bit; no wrap-around or arithmetic. Decode is an exact compare.

Test Plan:
- Reset, then AW addr 3 and W 8'h5C in the same cycle, B_READY=1 → B_VALID high for one cycle 2 edges later with BRESPONSE=0. Then AR addr 3 → R_VALID after 1 edge with data_read=8'h5C.
- W 8'h11 three cycles before AW addr 7 → W_READY low while held. Commit one edge after the AW handshake. Reading addr 7 returns 8'h11.
- Write 8'hFF to addr 15 → BRESPONSE=2 and reg unchanged. Reading addr 15 returns 8'hA5. With NUM_REGS=8, write addr 9 → BRESPONSE=3 and reading addr 9 returns 0.
- B_READY held low 5 cycles after the first write → B_VALID and BRESPONSE stable, AW_READY/W_READY low after the second AW/W is captured. The second commit occurs one edge after B_READY rises.
- R_READY low 4 cycles → R_VALID and data_read stable, AR_READY=0 throughout. The next AR is accepted on the edge after the R handshake completes.
- Assert rst for 1 cycle while B_VALID=1 and aw_full=1 → all outputs return to reset values, regs read back 0, and no write from the held address occurs.

Source files
------------

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite register-file slave: NUM_REGS x 8-bit R/W registers plus a read-only ID register.
// AW and W are captured independently; a write commits once both are held and no response is pending.
module axi_lite_regfile_slave #(
  parameter int unsigned NUM_REGS = 15,
  parameter logic [3:0]  ID_ADDR  = 4'd15,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] read_address,
  input  logic       AR_VALID,
  output logic       AR_READY,
  output logic [7:0] data_read,
  output logic       R_VALID,
  input  logic       R_READY,
  input  logic [3:0] write_address,
  input  logic       AW_VALID,
  output logic       AW_READY,
  input  logic [7:0] data_write,
  input  logic       W_VALID,
  output logic       W_READY,
  output logic       B_VALID,
  output logic [3:0] BRESPONSE,
  input  logic       B_READY
);

  typedef enum logic [3:0] {
    RESP_OKAY   = 4'd0,
    RESP_SLVERR = 4'd2,
    RESP_DECERR = 4'd3
  } resp_e;

  logic       aw_full_q, aw_full_d;
  logic [3:0] aw_addr_q, aw_addr_d;
  logic       w_full_q, w_full_d;
  logic [7:0] w_data_q, w_data_d;
  logic       b_valid_q, b_valid_d;
  resp_e      bresp_q, bresp_d;
  logic       r_valid_q, r_valid_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       commit;
  logic       aw_hit;
  logic       ar_hit;
  logic [7:0] ar_reg;

  assign AW_READY  = !aw_full_q;
  assign W_READY   = !w_full_q;
  assign AR_READY  = !r_valid_q;
  assign B_VALID   = b_valid_q;
  assign BRESPONSE = bresp_q;
  assign R_VALID   = r_valid_q;
  assign data_read = rdata_q;

  assign commit = aw_full_q && w_full_q && !b_valid_q;

  // Exact-compare decode; the ID address never aliases a R/W register.
  always_comb begin
    aw_hit = 1'b0;
    ar_hit = 1'b0;
    ar_reg = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (aw_addr_q == 4'(i)) aw_hit = 1'b1;
      if (read_address == 4'(i)) begin
        ar_hit = 1'b1;
        ar_reg = regs_q[i];
      end
    end
    if (aw_addr_q == ID_ADDR)    aw_hit = 1'b0;
    if (read_address == ID_ADDR) ar_hit = 1'b0;
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    b_valid_d = b_valid_q;
    bresp_d   = bresp_q;
    r_valid_d = r_valid_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;

    if (AW_VALID && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = write_address;
    end
    if (W_VALID && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = data_write;
    end

    // commit requires both holders full, so it never collides with a capture above
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      if (aw_hit) begin
        bresp_d = RESP_OKAY;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (aw_addr_q == 4'(i)) regs_d[i] = w_data_q;
        end
      end else if (aw_addr_q == ID_ADDR) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_DECERR;
      end
    end else if (b_valid_q && B_READY) begin
      b_valid_d = 1'b0;
      bresp_d   = RESP_OKAY;
    end

    if (AR_VALID && !r_valid_q) begin
      r_valid_d = 1'b1;
      if (read_address == ID_ADDR) rdata_d = ID_VALUE;
      else if (ar_hit)             rdata_d = ar_reg;
      else                         rdata_d = '0;
    end else if (r_valid_q && R_READY) begin
      r_valid_d = 1'b0;
      rdata_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      b_valid_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_valid_q <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      b_valid_q <= b_valid_d;
      bresp_q   <= bresp_d;
      r_valid_q <= r_valid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Scoreboard bench: two slaves (NUM_REGS=15 and NUM_REGS=8) share one master stimulus;
// expected B/R responses are queued at issue and checked by a monitor at each handshake.
module tb_axi_lite_regfile_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ar_addr, aw_addr;
  logic       ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [7:0] wdata;

  logic       ar_ready15, r_valid15, aw_ready15, w_ready15, b_valid15;
  logic [7:0] rdata15;
  logic [3:0] bresp15;
  logic       ar_ready8, r_valid8, aw_ready8, w_ready8, b_valid8;
  logic [7:0] rdata8;
  logic [3:0] bresp8;

  int checks = 0;
  int errors = 0;

  logic [3:0] bq15[$], bq8[$];
  logic [7:0] rq15[$], rq8[$];

  always #5 clk = ~clk;

  axi_lite_regfile_slave u_dut15 (
    .clk(clk), .rst(rst),
    .read_address(ar_addr), .AR_VALID(ar_valid), .AR_READY(ar_ready15),
    .data_read(rdata15), .R_VALID(r_valid15), .R_READY(r_ready),
    .write_address(aw_addr), .AW_VALID(aw_valid), .AW_READY(aw_ready15),
    .data_write(wdata), .W_VALID(w_valid), .W_READY(w_ready15),
    .B_VALID(b_valid15), .BRESPONSE(bresp15), .B_READY(b_ready)
  );

  axi_lite_regfile_slave #(.NUM_REGS(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .read_address(ar_addr), .AR_VALID(ar_valid), .AR_READY(ar_ready8),
    .data_read(rdata8), .R_VALID(r_valid8), .R_READY(r_ready),
    .write_address(aw_addr), .AW_VALID(aw_valid), .AW_READY(aw_ready8),
    .data_write(wdata), .W_VALID(w_valid), .W_READY(w_ready8),
    .B_VALID(b_valid8), .BRESPONSE(bresp8), .B_READY(b_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a handshake is visible at the negedge before the edge that completes it.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_valid15 && b_ready) begin
        if (bq15.size() == 0) chk("b15_unexpected", 32'(bresp15), 32'hFFFF);
        else chk("b15_resp", 32'(bresp15), 32'(bq15.pop_front()));
      end
      if (b_valid8 && b_ready) begin
        if (bq8.size() == 0) chk("b8_unexpected", 32'(bresp8), 32'hFFFF);
        else chk("b8_resp", 32'(bresp8), 32'(bq8.pop_front()));
      end
      if (r_valid15 && r_ready) begin
        if (rq15.size() == 0) chk("r15_unexpected", 32'(rdata15), 32'hFFFF);
        else chk("r15_data", 32'(rdata15), 32'(rq15.pop_front()));
      end
      if (r_valid8 && r_ready) begin
        if (rq8.size() == 0) chk("r8_unexpected", 32'(rdata8), 32'hFFFF);
        else chk("r8_data", 32'(rdata8), 32'(rq8.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dut15"}, {15'd0, ar_ready15, aw_ready15, w_ready15, b_valid15, r_valid15, rdata15, bresp15},
        {15'd0, 3'b111, 2'b00, 8'h00, 4'h0});
    chk({tag, "_dut8"}, {15'd0, ar_ready8, aw_ready8, w_ready8, b_valid8, r_valid8, rdata8, bresp8},
        {15'd0, 3'b111, 2'b00, 8'h00, 4'h0});
  endtask

  // Tasks start and end just after a posedge.
  task automatic wait_write_ready();
    int n = 0;
    @(negedge clk);
    while (!(aw_ready15 && w_ready15 && aw_ready8 && w_ready8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("write_ready_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [3:0] e15, input logic [3:0] e8);
    aw_addr = a; wdata = d; aw_valid = 1'b1; w_valid = 1'b1;
    bq15.push_back(e15); bq8.push_back(e8);
    wait_write_ready();
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk); chk("b_not_early", {b_valid15, b_valid8}, 2'b00);
    @(negedge clk); chk("b_latency", {b_valid15, b_valid8}, 2'b11);
    @(negedge clk); chk("b_one_cycle", {b_valid15, b_valid8}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e15, input logic [7:0] e8);
    int n = 0;
    ar_addr = a; ar_valid = 1'b1;
    rq15.push_back(e15); rq8.push_back(e8);
    @(negedge clk);
    while (!(ar_ready15 && ar_ready8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(negedge clk); chk("r_latency", {r_valid15, r_valid8}, 2'b11);
    @(negedge clk); chk("r_one_cycle", {r_valid15, r_valid8}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ar_addr = '0; aw_addr = '0; wdata = '0;
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    r_ready = 1'b1; b_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk); #1;

    // AW and W on the same edge, then read back
    do_write(4'd3, 8'h5C, 4'd0, 4'd0);
    do_read(4'd3, 8'h5C, 8'h5C);

    // W three cycles ahead of AW
    wdata = 8'h11; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("w_ready_low_while_held", {w_ready15, w_ready8, aw_ready15, aw_ready8}, 4'b0011);
      @(posedge clk); #1;
    end
    aw_addr = 4'd7; aw_valid = 1'b1;
    bq15.push_back(4'd0); bq8.push_back(4'd0);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    @(negedge clk); chk("w_first_not_early", {b_valid15, b_valid8}, 2'b00);
    @(negedge clk); chk("w_first_commit", {b_valid15, b_valid8}, 2'b11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_read(4'd7, 8'h11, 8'h11);

    // ID register and decode boundaries
    do_write(4'd15, 8'hFF, 4'd2, 4'd2);
    do_read(4'd15, 8'hA5, 8'hA5);
    do_write(4'd9, 8'h3C, 4'd0, 4'd3);
    do_read(4'd9, 8'h3C, 8'h00);
    do_write(4'd8, 8'h42, 4'd0, 4'd3);
    do_read(4'd8, 8'h42, 8'h00);
    do_read(4'd0, 8'h00, 8'h00);

    // B back-pressure with a second write captured behind the pending response
    b_ready = 1'b0;
    aw_addr = 4'd15; wdata = 8'h99; aw_valid = 1'b1; w_valid = 1'b1;
    bq15.push_back(4'd2); bq8.push_back(4'd2);
    bq15.push_back(4'd0); bq8.push_back(4'd0);
    @(posedge clk); #1;
    aw_addr = 4'd2; wdata = 8'hB2;
    @(posedge clk);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("b_stall_stable", {b_valid15, bresp15, aw_ready15, w_ready15, b_valid8, bresp8, aw_ready8, w_ready8},
          {1'b1, 4'd2, 2'b00, 1'b1, 4'd2, 2'b00});
      @(posedge clk); #1;
    end
    b_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); chk("b_cleared_held", {b_valid15, aw_ready15, b_valid8, aw_ready8}, 4'b0000);
    @(negedge clk); chk("second_commit", {b_valid15, aw_ready15, b_valid8, aw_ready8}, 4'b1111);
    @(negedge clk); chk("second_b_done", {b_valid15, b_valid8}, 2'b00);
    @(posedge clk); #1;

    // R back-pressure with a second AR waiting
    r_ready = 1'b0;
    ar_addr = 4'd2; ar_valid = 1'b1;
    rq15.push_back(8'hB2); rq8.push_back(8'hB2);
    @(posedge clk); #1;
    ar_addr = 4'd7;
    rq15.push_back(8'h11); rq8.push_back(8'h11);
    repeat (4) begin
      @(negedge clk);
      chk("r_stall_stable", {r_valid15, rdata15, ar_ready15, r_valid8, rdata8, ar_ready8},
          {1'b1, 8'hB2, 1'b0, 1'b1, 8'hB2, 1'b0});
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("r_released", {r_valid15, ar_ready15, r_valid8, ar_ready8}, 4'b0101);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(negedge clk); chk("next_ar_accepted", {r_valid15, r_valid8}, 2'b11);
    @(negedge clk); chk("next_r_done", {r_valid15, r_valid8}, 2'b00);
    @(posedge clk); #1;

    // Reset with a pending B and a held AW/W
    b_ready = 1'b0;
    aw_addr = 4'd4; wdata = 8'hD4; aw_valid = 1'b1; w_valid = 1'b1;
    @(posedge clk); #1;
    aw_addr = 4'd5; wdata = 8'hE5;
    @(posedge clk);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk); chk("pre_reset_state", {b_valid15, aw_ready15, w_ready15}, 3'b100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset_values");
    repeat (3) begin
      @(negedge clk);
      chk("no_commit_after_reset", {b_valid15, b_valid8}, 2'b00);
    end
    @(posedge clk); #1;
    do_read(4'd4, 8'h00, 8'h00);
    do_read(4'd5, 8'h00, 8'h00);
    do_read(4'd3, 8'h00, 8'h00);
    do_read(4'd2, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    chk("bq_drained", 32'(bq15.size() + bq8.size()), 32'd0);
    chk("rq_drained", 32'(rq15.size() + rq8.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
